traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//   Phase sequencer that drives the one-hot phase inputs HR/HY/HG/FR/FY/FG of the
//   highway/farm light block. It consumes that block's latched request flags:
//   AMB (ambulance) and C (farm car).
//   Timed 4-phase FSM: highway green -> highway yellow -> farm green -> farm yellow.
//   Dwell times are counted in ticks of a clock prescaler.
//   Farm-green duration is extended by requests and bounded by maximum limits.
// PARAMETERS
//   TICK_DIV  4   clock cycles per tick (>=1)
//   HG_MIN    8   minimum highway-green dwell, ticks (>=1)
//   YEL_T     2   yellow dwell, both roads, ticks (>=1)
//   FG_MIN    2   farm-green dwell when no request is pending, ticks (>=1)
//   FG_MAX    6   farm-green limit while C is held, ticks (FG_MIN<=FG_MAX)
//   AMB_MAX   12  farm-green hard limit while AMB is held, ticks (FG_MAX<=AMB_MAX)
// PORTS
//   Clk    in   1  clock, all state on rising edge
//   RS_n   in   1  reset, synchronous, active-low
//   AMB    in   1  ambulance request, level, from light block
//   C      in   1  farm-car request, level, from light block
//   HR     out  1  highway red phase
//   HY     out  1  highway yellow phase
//   HG     out  1  highway green phase
//   FR     out  1  farm red phase
//   FY     out  1  farm yellow phase
//   FG     out  1  farm green phase
//   PHASE  out  2  current state code: 0=S_HG 1=S_HY 2=S_FG 3=S_FY
// BEHAVIOUR
// - Reset (RS_n==0 at an edge, in any state, mid-dwell included):
//   state=S_HG, pre=0, tmr=0, HG=1, FR=1, HR=HY=FY=FG=0, PHASE=0.
// - All outputs are registered and decoded from the next state, so they change on
//   the same edge as the state. Outputs per state:
//   S_HG: HG+FR; S_HY: HY+FR; S_FG: FG+HR; S_FY: FY+HR. Exactly two outputs high.
// - Timer: pre counts 0..TICK_DIV-1; tick = (pre==TICK_DIV-1); on tick pre->0 and
//   tmr increments, saturating at 8'hFF.
//   On every state change, pre=0 and tmr=0 on the same edge.
//   Let t = tmr+1, evaluated only in a tick cycle.
// - Transitions occur only on tick edges. Dwell of N ticks = exactly N*TICK_DIV cycles.
//   S_HG -> S_HY when t>=HG_MIN && (AMB||C). Without requests, stay in S_HG forever.
//   S_HY -> S_FG when t==YEL_T. Requests are ignored.
//   S_FG -> S_FY when any of the following holds:
//     - t>=AMB_MAX
//     - !AMB && t>=FG_MAX
//     - !AMB && !C && t>=FG_MIN
//   S_FY -> S_HG when t==YEL_T. Requests are ignored.
// - Requests arriving before HG_MIN are held by the light block. The exit then
//   happens at the first tick with t>=HG_MIN.
// - AMB and C asserted together: identical to AMB alone (AMB_MAX bound applies).
// - A request deasserting mid-S_FG is re-evaluated at the next tick.
//   The light block clears its flags only while FG=1, so a drop is seen >=1 cycle
//   after S_FG entry.
// - AMB or C dropping in S_HG before HG_MIN: no transition; wait for a new request.
// - Unused state encodings are not reachable. If one is decoded, go to S_HG on the
//   next edge.
// STRUCTURE
//   traffic_pkg holds:
//     - phase codes S_HG/S_HY/S_FG/S_FY
//     - light codes red=3'b100, green=3'b010, yellow=3'b110, white=3'b111
//       (shared with the light block)
//     - tick/timer width constant TMR_W=8
//   Sub-module phase_timer: prescaler plus saturating tick counter, with ports
//   clr (state change), tick, tmr.
//   The FSM and output decode stay in this module.
// TESTING (defaults, cycle 0 = first edge with RS_n=1)
// 1. RS_n=0 for 2 edges from random state -> HG=1, FR=1, others 0, PHASE=0.
// 2. No requests for 200 cycles -> PHASE stays 0; outputs constant HG+FR.
// 3. C=1 from cycle 5, drop 1 cycle after FG rises:
//    HY at cycle 32, FG at 40, FY at 48, HG at 56.
// 4. C held high throughout -> S_FG lasts 24 cycles (FG_MAX), then FY 8 cycles,
//    then HG. Next HY occurs 32 cycles after HG entry.
// 5. AMB held high throughout, also with C=1 -> S_FG lasts 48 cycles (AMB_MAX).
//    AMB dropped at S_FG cycle 30 -> FY entered at cycle 32 (next tick).
// 6. C=1 first asserted at cycle 41 -> HY on the cycle-44 tick edge.
//    RS_n=0 at S_FG cycle 3 -> next edge HG+FR, tmr=0. Check one-hot-pair invariant
//    every cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/farm phase sequencer and its light block:
// phase codes, light codes, timer width and the phase-to-lamp decode.
package traffic_pkg;

    localparam int unsigned TMR_W = 8;

    typedef enum logic [1:0] {
        S_HG = 2'd0,
        S_HY = 2'd1,
        S_FG = 2'd2,
        S_FY = 2'd3
    } phase_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b110;
    localparam logic [2:0] LIGHT_WHITE  = 3'b111;

    typedef struct packed {
        logic hr;
        logic hy;
        logic hg;
        logic fr;
        logic fy;
        logic fg;
    } lights_t;

    // Exactly one highway lamp and one farm lamp per phase; unknown codes fall back to S_HG.
    function automatic lights_t phase_lights(input phase_e ph);
        lights_t l;
        l = 6'b000000;
        case (ph)
            S_HG:    begin l.hg = 1'b1; l.fr = 1'b1; end
            S_HY:    begin l.hy = 1'b1; l.fr = 1'b1; end
            S_FG:    begin l.fg = 1'b1; l.hr = 1'b1; end
            S_FY:    begin l.fy = 1'b1; l.hr = 1'b1; end
            default: begin l.hg = 1'b1; l.fr = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Clock prescaler plus saturating tick counter measuring dwell time in the current phase.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic             Clk,
    input  logic             RS_n,
    input  logic             clr,
    output logic             tick,
    output logic [TMR_W-1:0] tmr
);

    localparam int unsigned     PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic [TMR_W-1:0] tmr_r;

    assign tick = (pre_r == PRE_LAST);
    assign tmr  = tmr_r;

    // Prescaler and tick counter; a phase change restarts both on the same edge.
    always_ff @(posedge Clk) begin
        if (!RS_n) begin
            pre_r <= {PRE_W{1'b0}};
            tmr_r <= {TMR_W{1'b0}};
        end else if (clr) begin
            pre_r <= {PRE_W{1'b0}};
            tmr_r <= {TMR_W{1'b0}};
        end else if (tick) begin
            pre_r <= {PRE_W{1'b0}};
            if (tmr_r != {TMR_W{1'b1}}) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end else begin
                tmr_r <= tmr_r;
            end
        end else begin
            pre_r <= pre_r + PRE_W'(1);
            tmr_r <= tmr_r;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-phase highway/farm sequencer: timed dwell per phase, farm green stretched by
// car/ambulance requests up to hard limits, lamp outputs registered from the next state.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned HG_MIN   = 8,
    parameter int unsigned YEL_T    = 2,
    parameter int unsigned FG_MIN   = 2,
    parameter int unsigned FG_MAX   = 6,
    parameter int unsigned AMB_MAX  = 12
) (
    input  logic       Clk,
    input  logic       RS_n,
    input  logic       AMB,
    input  logic       C,
    output logic       HR,
    output logic       HY,
    output logic       HG,
    output logic       FR,
    output logic       FY,
    output logic       FG,
    output logic [1:0] PHASE
);

    // One extra bit so t = tmr+1 cannot wrap when tmr is saturated.
    localparam int unsigned     T_W       = TMR_W + 1;
    localparam logic [T_W-1:0]  HG_MIN_T  = T_W'(HG_MIN);
    localparam logic [T_W-1:0]  YEL_T_T   = T_W'(YEL_T);
    localparam logic [T_W-1:0]  FG_MIN_T  = T_W'(FG_MIN);
    localparam logic [T_W-1:0]  FG_MAX_T  = T_W'(FG_MAX);
    localparam logic [T_W-1:0]  AMB_MAX_T = T_W'(AMB_MAX);

    phase_e           state_r;
    phase_e           nxt_s;
    lights_t          lights_r;
    logic             tick_s;
    logic             clr_s;
    logic [TMR_W-1:0] tmr_s;
    logic [T_W-1:0]   t_s;

    phase_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .Clk (Clk),
        .RS_n(RS_n),
        .clr (clr_s),
        .tick(tick_s),
        .tmr (tmr_s)
    );

    // Next-phase selection; every exit is gated by a tick so dwells are whole ticks.
    always_comb begin
        t_s   = {1'b0, tmr_s} + T_W'(1);
        nxt_s = state_r;
        case (state_r)
            S_HG: begin
                if (tick_s && (t_s >= HG_MIN_T) && (AMB || C)) nxt_s = S_HY;
                else                                           nxt_s = S_HG;
            end
            S_HY: begin
                if (tick_s && (t_s == YEL_T_T)) nxt_s = S_FG;
                else                            nxt_s = S_HY;
            end
            S_FG: begin
                if (tick_s && ((t_s >= AMB_MAX_T) ||
                               (!AMB && (t_s >= FG_MAX_T)) ||
                               (!AMB && !C && (t_s >= FG_MIN_T)))) nxt_s = S_FY;
                else                                               nxt_s = S_FG;
            end
            S_FY: begin
                if (tick_s && (t_s == YEL_T_T)) nxt_s = S_HG;
                else                            nxt_s = S_FY;
            end
            default: nxt_s = S_HG;
        endcase
    end

    assign clr_s = (nxt_s != state_r);

    // Phase register with lamp outputs decoded from the next phase so both move together.
    always_ff @(posedge Clk) begin
        if (!RS_n) begin
            state_r  <= S_HG;
            lights_r <= phase_lights(S_HG);
        end else begin
            state_r  <= nxt_s;
            lights_r <= phase_lights(nxt_s);
        end
    end

    assign HR    = lights_r.hr;
    assign HY    = lights_r.hy;
    assign HG    = lights_r.hg;
    assign FR    = lights_r.fr;
    assign FY    = lights_r.fy;
    assign FG    = lights_r.fg;
    assign PHASE = state_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus randomized requests
// and resets, compared against a tick-arithmetic model of the phase rules.
module tb_traffic_phase_ctrl;

    localparam int TD      = 4;
    localparam int HG_MIN  = 8;
    localparam int YEL_T   = 2;
    localparam int FG_MIN  = 2;
    localparam int FG_MAX  = 6;
    localparam int AMB_MAX = 12;

    logic       clk = 1'b0;
    logic       rs_n = 1'b0;
    logic       amb = 1'b0;
    logic       c = 1'b0;
    logic       hr, hy, hg, fr, fy, fg;
    logic [1:0] phase;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model: phase index and edges spent in it
    int m_phase = 0;
    int m_n     = 0;

    // observation of the DUT
    int e_cnt = 0;
    int prev_ph = 0;
    int run_len = 0;
    int ret_hg = -1;
    int first_seen[4];
    int last_run[4];

    traffic_phase_ctrl #(
        .TICK_DIV(TD), .HG_MIN(HG_MIN), .YEL_T(YEL_T),
        .FG_MIN(FG_MIN), .FG_MAX(FG_MAX), .AMB_MAX(AMB_MAX)
    ) dut (
        .Clk(clk), .RS_n(rs_n), .AMB(amb), .C(c),
        .HR(hr), .HY(hy), .HG(hg), .FR(fr), .FY(fy), .FG(fg),
        .PHASE(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_lights(input int ph);
        case (ph)
            0:       return 6'b001100;
            1:       return 6'b010100;
            2:       return 6'b100001;
            3:       return 6'b100010;
            default: return 6'b000000;
        endcase
    endfunction

    // One clock edge: advance the model from the inputs seen at the edge, then observe the DUT.
    task automatic step();
        int t;
        bit go;
        @(posedge clk);
        if (!rs_n) begin
            m_phase = 0;
            m_n     = 0;
            e_cnt   = 0;
            prev_ph = 0;
            run_len = 0;
            ret_hg  = -1;
            for (int k = 0; k < 4; k++) begin
                first_seen[k] = -1;
                last_run[k]   = -1;
            end
        end else begin
            go = 1'b0;
            if ((m_n + 1) % TD == 0) begin
                t = (m_n + 1) / TD;
                if (t > 256) t = 256;
                case (m_phase)
                    0: go = (t >= HG_MIN) && (amb || c);
                    1: go = (t == YEL_T);
                    2: go = (t >= AMB_MAX) || (!amb && t >= FG_MAX) || (!amb && !c && t >= FG_MIN);
                    default: go = (t == YEL_T);
                endcase
            end
            if (go) begin
                m_phase = (m_phase + 1) % 4;
                m_n     = 0;
            end else begin
                m_n++;
            end
            e_cnt++;
        end
        #1;
        if (!$isunknown(phase)) begin
            if (int'(phase) == prev_ph) begin
                run_len++;
            end else begin
                last_run[prev_ph] = run_len;
                if (int'(phase) == 0 && prev_ph == 3 && ret_hg < 0) ret_hg = e_cnt;
                run_len = 1;
                prev_ph = int'(phase);
            end
            if (first_seen[phase] < 0) first_seen[phase] = e_cnt;
        end
    endtask

    task automatic do_reset();
        rs_n = 1'b0;
        step();
        step();
        rs_n = 1'b1;
    endtask

    task automatic test_reset(input string tag);
        rs_n = 1'b0;
        step();
        step();
        chk_cnt++;
        if ({hr, hy, hg, fr, fy, fg} !== 6'b001100 || phase !== 2'd0)
            $display("FAIL %s: lights=%b phase=%0d, expected lights=001100 phase=0", tag, {hr, hy, hg, fr, fy, fg}, phase);
        else pass_cnt++;
        rs_n = 1'b1;
    endtask

    task automatic test_idle();
        do_reset();
        amb = 1'b0;
        c   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            chk_cnt++;
            if ({hr, hy, hg, fr, fy, fg} !== 6'b001100 || phase !== 2'd0)
                $display("FAIL idle cyc %0d: lights=%b phase=%0d, expected 001100/0", e_cnt, {hr, hy, hg, fr, fy, fg}, phase);
            else pass_cnt++;
        end
    endtask

    task automatic test_c_drop();
        do_reset();
        amb = 1'b0;
        for (int i = 0; i < 70; i++) begin
            c = (e_cnt >= 5) && !(first_seen[2] >= 0 && e_cnt >= first_seen[2] + 1);
            step();
            chk_cnt++;
            if ({hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase) || phase !== 2'(m_phase))
                $display("FAIL c_drop cyc %0d: lights=%b phase=%0d, expected %b/%0d", e_cnt, {hr, hy, hg, fr, fy, fg}, phase, exp_lights(m_phase), m_phase);
            else pass_cnt++;
        end
        c = 1'b0;
        chk_cnt++;
        if (first_seen[1] != 32 || first_seen[2] != 40 || first_seen[3] != 48 || ret_hg != 56)
            $display("FAIL c_drop timing: HY=%0d FG=%0d FY=%0d HG=%0d, expected 32 40 48 56", first_seen[1], first_seen[2], first_seen[3], ret_hg);
        else pass_cnt++;
    endtask

    task automatic test_c_hold();
        do_reset();
        amb = 1'b0;
        c   = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            chk_cnt++;
            if ({hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase) || phase !== 2'(m_phase))
                $display("FAIL c_hold cyc %0d: lights=%b phase=%0d, expected %b/%0d", e_cnt, {hr, hy, hg, fr, fy, fg}, phase, exp_lights(m_phase), m_phase);
            else pass_cnt++;
        end
        c = 1'b0;
        chk_cnt++;
        if (last_run[2] != 24 || last_run[3] != 8 || last_run[0] != 32)
            $display("FAIL c_hold dwell: FG=%0d FY=%0d HG=%0d, expected 24 8 32", last_run[2], last_run[3], last_run[0]);
        else pass_cnt++;
    endtask

    task automatic test_amb();
        for (int cv = 0; cv < 2; cv++) begin
            do_reset();
            amb = 1'b1;
            c   = 1'(cv);
            for (int i = 0; i < 150; i++) begin
                step();
                chk_cnt++;
                if ({hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase) || phase !== 2'(m_phase))
                    $display("FAIL amb c=%0d cyc %0d: lights=%b phase=%0d, expected %b/%0d", cv, e_cnt, {hr, hy, hg, fr, fy, fg}, phase, exp_lights(m_phase), m_phase);
                else pass_cnt++;
            end
            chk_cnt++;
            if (last_run[2] != 48)
                $display("FAIL amb_hold c=%0d: FG dwell=%0d, expected 48", cv, last_run[2]);
            else pass_cnt++;
        end
        do_reset();
        amb = 1'b1;
        c   = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (prev_ph == 2 && run_len == 30) amb = 1'b0;
            step();
            chk_cnt++;
            if ({hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase) || phase !== 2'(m_phase))
                $display("FAIL amb_drop cyc %0d: lights=%b phase=%0d, expected %b/%0d", e_cnt, {hr, hy, hg, fr, fy, fg}, phase, exp_lights(m_phase), m_phase);
            else pass_cnt++;
        end
        amb = 1'b0;
        chk_cnt++;
        if (last_run[2] != 32)
            $display("FAIL amb_drop: FG dwell=%0d, expected 32", last_run[2]);
        else pass_cnt++;
    endtask

    task automatic test_late_c();
        bit hit;
        do_reset();
        amb = 1'b0;
        c   = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (e_cnt >= 41) c = 1'b1;
            if (prev_ph == 2 && run_len == 3) begin
                hit  = 1'b1;
                rs_n = 1'b0;
            end
            step();
            chk_cnt++;
            if ($countones({hr, hy, hg, fr, fy, fg}) != 2 || {hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase))
                $display("FAIL late_c cyc %0d: lights=%b, expected %b", e_cnt, {hr, hy, hg, fr, fy, fg}, exp_lights(m_phase));
            else pass_cnt++;
            if (!hit && first_seen[1] > 0 && i < 60) begin
                chk_cnt++;
                if (first_seen[1] != 44) $display("FAIL late_c HY: first HY cyc=%0d, expected 44", first_seen[1]);
                else pass_cnt++;
                first_seen[1] = 0;
            end
        end
        chk_cnt++;
        if (!hit || rs_n !== 1'b0 || {hr, hy, hg, fr, fy, fg} !== 6'b001100 || phase !== 2'd0)
            $display("FAIL mid_fg_reset: reached=%0d lights=%b phase=%0d, expected 001100/0", hit, {hr, hy, hg, fr, fy, fg}, phase);
        else pass_cnt++;
        rs_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk_cnt++;
            if ($countones({hr, hy, hg, fr, fy, fg}) != 2 || phase !== 2'(m_phase))
                $display("FAIL after_reset cyc %0d: lights=%b phase=%0d, expected phase %0d", e_cnt, {hr, hy, hg, fr, fy, fg}, phase, m_phase);
            else pass_cnt++;
        end
        c = 1'b0;
        chk_cnt++;
        if (first_seen[1] != 32)
            $display("FAIL after_reset HY: first HY cyc=%0d, expected 32", first_seen[1]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        amb = 1'b0;
        c   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) amb = ~amb;
            if ($urandom_range(0, 7) == 0)  c   = ~c;
            rs_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step();
            chk_cnt++;
            if ({hr, hy, hg, fr, fy, fg} !== exp_lights(m_phase) || phase !== 2'(m_phase))
                $display("FAIL random cyc %0d: lights=%b phase=%0d, expected %b/%0d", i, {hr, hy, hg, fr, fy, fg}, phase, exp_lights(m_phase), m_phase);
            else pass_cnt++;
        end
        rs_n = 1'b1;
        amb  = 1'b1;
        c    = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            first_seen[k] = -1;
            last_run[k]   = -1;
        end
        test_reset("reset_init");
        test_idle();
        test_c_drop();
        test_c_hold();
        test_amb();
        test_late_c();
        test_random();
        for (int i = 0; i < 57; i++) step();
        test_reset("reset_from_busy");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
